// File: rtl/nibble_serial_subtractor.sv
// Unsigned subtractor that processes one 4-bit digit slice per clock, LSB first,
// with a ready/valid handshake on both the operand and the result side.
`timescale 1ns/1ps

module nibble_serial_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] diff,
    output logic                 borrow,
    output logic                 busy
);

    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] diff_reg;
    logic [3:0]   idx;
    logic         borrow_acc;
    logic         borrow_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic         busy_reg;
    logic [3:0]   a_nib;
    logic [3:0]   b_nib;
    logic [4:0]   nib_sub;

    // Select the digit slice addressed by idx from the captured operands.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == 4'(i)) begin
                a_nib = a_reg[i*4 +: 4];
                b_nib = b_reg[i*4 +: 4];
            end
        end
    end

    // A negative 5-bit result wraps, leaving bit 4 set: that is the nibble borrow-out.
    assign nib_sub = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            diff_reg      <= '0;
            idx           <= '0;
            borrow_acc    <= 1'b0;
            borrow_reg    <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        diff_reg     <= '0;
                        borrow_reg   <= 1'b0;
                        idx          <= '0;
                        borrow_acc   <= 1'b0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == 4'(i)) begin
                            diff_reg[i*4 +: 4] <= nib_sub[3:0];
                        end
                    end
                    borrow_acc <= nib_sub[4];
                    idx        <= idx + 4'd1;
                    if (idx == 4'(NIBBLES - 1)) begin
                        borrow_reg    <= nib_sub[4];
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // Result is held until the transfer; re-arming waits one cycle.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign diff      = diff_reg;
    assign borrow    = borrow_reg;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (NIBBLES=4) against a plain
// arithmetic model: diff = (a - b) mod 2^16, borrow = (a < b).
`timescale 1ns/1ps

module tb_nibble_serial_subtractor;

    localparam int NIB    = 4;
    localparam int W      = 4 * NIB;
    localparam int NPAIRS = 1000;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;

    int errors;
    int checks;

    nibble_serial_subtractor #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h0001;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (diff !== 16'h0000) begin errors++; $display("[TB] FAIL rst_diff: got %h expected 0000", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("[TB] FAIL rst_borrow: got %b expected 0", borrow); end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_idle: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic [W-1:0] exp_d;
        logic         exp_b;
        int           n;
        ta[0] = 16'h0008; tb[0] = 16'h0003;
        ta[1] = 16'h1000; tb[1] = 16'h0001;
        ta[2] = 16'h0000; tb[2] = 16'h0005;
        ta[3] = 16'hFFFF; tb[3] = 16'hFFFF;
        for (int v = 0; v < 4; v++) begin
            exp_d = ta[v] - tb[v];
            exp_b = (ta[v] < tb[v]);
            @(posedge clk);
            #1;
            a         = ta[v];
            b         = tb[v];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = 16'($urandom);
            b        = 16'($urandom);
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_accept: got busy=%b in_ready=%b expected 1/0", v, busy, in_ready); end
            n = 1;
            while (out_valid !== 1'b1 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++; if (n !== NIB + 1) begin errors++; $display("[TB] FAIL dir%0d_latency: got %0d edges expected %0d", v, n, NIB + 1); end
            checks++; if (diff !== exp_d) begin errors++; $display("[TB] FAIL dir%0d_diff: got %h expected %h", v, diff, exp_d); end
            checks++; if (borrow !== exp_b) begin errors++; $display("[TB] FAIL dir%0d_borrow: got %b expected %b", v, borrow, exp_b); end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_transfer: got out_valid=%b in_ready=%b expected 0/1", v, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_d;
        logic         exp_b;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        int           n;
        exp_d = 16'h4321 - 16'h5000;
        exp_b = (16'h4321 < 16'h5000);
        a2    = 16'h0F0F;
        b2    = 16'h00F0;
        @(posedge clk);
        #1;
        a         = 16'h4321;
        b         = 16'h5000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_done_timeout: got out_valid=%b expected 1", out_valid); end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            @(posedge clk);
            #1;
            checks++; if (diff !== exp_d || borrow !== exp_b) begin errors++; $display("[TB] FAIL bp_hold%0d: got %h/%b expected %h/%b", k, diff, borrow, exp_d, exp_b); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall%0d: got in_ready=%b out_valid=%b expected 0/1", k, in_ready, out_valid); end
        end
        a         = a2;
        b         = b2;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_turnaround: got out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_accept_after: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (diff !== 16'(a2 - b2) || borrow !== (a2 < b2)) begin errors++; $display("[TB] FAIL bp_second: got %h/%b expected %h/%b", diff, borrow, 16'(a2 - b2), (a2 < b2)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] exp_d;
        logic         exp_b;
        int           n;
        exp_d = 16'h0005 - 16'h0007;
        exp_b = (16'h0005 < 16'h0007);
        @(posedge clk);
        #1;
        a         = 16'h1234;
        b         = 16'h0001;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (diff[15:4] !== 12'h000 || busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_partial: got diff=%h busy=%b expected 000x/1", diff, busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_idle: got in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy); end
        checks++; if (diff !== 16'h0000 || borrow !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_clear: got %h/%b expected 0000/0", diff, borrow); end
        a        = 16'h0005;
        b        = 16'h0007;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== NIB + 1) begin errors++; $display("[TB] FAIL mid_latency: got %0d edges expected %0d", n, NIB + 1); end
        checks++; if (diff !== exp_d || borrow !== exp_b) begin errors++; $display("[TB] FAIL mid_after: got %h/%b expected %h/%b", diff, borrow, exp_d, exp_b); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [W:0] expq [$];
        logic [W:0] exp_v;
        logic [W:0] got_v;
        int         sent;
        int         received;
        int         cycles;
        logic       acc;
        logic       xfer;
        int         r;
        sent     = 0;
        received = 0;
        cycles   = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while (received < NPAIRS && cycles < 40000) begin
            @(negedge clk);
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_extra: got unexpected result %h/%b expected none", diff, borrow);
                end else begin
                    exp_v = expq.pop_front();
                    got_v = {borrow, diff};
                    if (got_v !== exp_v) begin
                        errors++;
                        $display("[TB] FAIL b2b_result%0d: got %h/%b expected %h/%b", received, got_v[W-1:0], got_v[W], exp_v[W-1:0], exp_v[W]);
                    end
                    received++;
                end
            end
            if (acc) begin
                expq.push_back({(a < b), 16'(a - b)});
                sent++;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (acc || !in_valid) begin
                if (sent < NPAIRS && $urandom_range(0, 3) != 0) begin
                    r        = int'($urandom_range(0, 5));
                    in_valid = 1'b1;
                    a        = 16'($urandom);
                    b        = (r == 0) ? a : (r == 1) ? 16'hFFFF : (r == 2) ? 16'h0000 : 16'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end
        checks++;
        if (received != NPAIRS || expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_count: got received=%0d pending=%0d expected %0d/0", received, expq.size(), NPAIRS);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
